// File: rtl/in_dispatcher.sv
// Ingress packet dispatcher: steers each AXI4-Stream packet into one of six
// destination FIFOs. Optional feature macro: DISPATCH_DROP_ON_FULL_EN.
module in_dispatcher #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    o_fifo_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  o_fifo_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   o_fifo_tuser,
    output logic                              o_fifo_tlast,
    output logic                              o_fifo_wr_en_d,
    output logic                              o_fifo_wr_en_0,
    output logic                              o_fifo_wr_en_1,
    output logic                              o_fifo_wr_en_2,
    output logic                              o_fifo_wr_en_3,
    output logic                              o_fifo_wr_en_4,
    input  logic                              i_fifo_full_d,
    input  logic                              i_fifo_full_0,
    input  logic                              i_fifo_full_1,
    input  logic                              i_fifo_full_2,
    input  logic                              i_fifo_full_3,
    input  logic                              i_fifo_full_4,
    output logic [31:0]                       o_drop_cnt
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    // Destination index: 0..4 are the numbered FIFOs, 5 is the default FIFO d.
    function automatic logic [2:0] decode_dest(input logic [7:0] b);
        case (b)
            8'h01:                      decode_dest = 3'd0;
            8'h04:                      decode_dest = 3'd1;
            8'h10:                      decode_dest = 3'd2;
            8'h40:                      decode_dest = 3'd3;
            8'h02, 8'h08, 8'h20, 8'h80: decode_dest = 3'd4;
            default:                    decode_dest = 3'd5;
        endcase
    endfunction

    state_t                          state_q, state_d;
    logic [2:0]                      dest_q, dest_d;
    logic [5:0]                      wr_en_q, wr_en_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [KEEP_W-1:0]               tkeep_q, tkeep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic                            tlast_q, tlast_d;
    logic [31:0]                     drop_cnt_q, drop_cnt_d;

    logic [7:0] full_s;
    logic [2:0] dec_s;
    logic [2:0] sel_s;
    logic       tready_s;
    logic       wr_s;
    logic       drop_s;

    assign full_s = {2'b00, i_fifo_full_d, i_fifo_full_4, i_fifo_full_3,
                     i_fifo_full_2, i_fifo_full_1, i_fifo_full_0};
    assign dec_s  = decode_dest(s_axis_tuser[31:24]);

    // Next-state, ready and write-select logic.
    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        sel_s    = dest_q;
        tready_s = 1'b0;
        wr_s     = 1'b0;
        drop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                sel_s = dec_s;
`ifdef DISPATCH_DROP_ON_FULL_EN
                tready_s = 1'b1;
                if (s_axis_tvalid) begin
                    if (full_s[dec_s]) begin
                        drop_s  = 1'b1;
                        state_d = s_axis_tlast ? IDLE : DROP;
                    end else begin
                        wr_s    = 1'b1;
                        dest_d  = dec_s;
                        state_d = s_axis_tlast ? IDLE : FWD;
                    end
                end else begin
                    state_d = IDLE;
                end
`else
                tready_s = !full_s[dec_s];
                if (s_axis_tvalid && tready_s) begin
                    wr_s    = 1'b1;
                    dest_d  = dec_s;
                    state_d = s_axis_tlast ? IDLE : FWD;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            FWD: begin
                tready_s = !full_s[dest_q];
                if (s_axis_tvalid && tready_s) begin
                    wr_s    = 1'b1;
                    state_d = s_axis_tlast ? IDLE : FWD;
                end else begin
                    state_d = FWD;
                end
            end
            DROP: begin
                tready_s = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write bus next values: data holds when there is no handshake.
    always_comb begin
        if (wr_s) begin
            wr_en_d = 6'b000001 << sel_s;
            tdata_d = s_axis_tdata;
            tkeep_d = s_axis_tkeep;
            tuser_d = s_axis_tuser;
            tlast_d = s_axis_tlast;
        end else begin
            wr_en_d = 6'd0;
            tdata_d = tdata_q;
            tkeep_d = tkeep_q;
            tuser_d = tuser_q;
            tlast_d = tlast_q;
        end
        if (drop_s) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State, destination latch and registered write bus.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q    <= IDLE;
            dest_q     <= 3'd0;
            wr_en_q    <= 6'd0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tuser_q    <= '0;
            tlast_q    <= 1'b0;
            drop_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            wr_en_q    <= wr_en_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign s_axis_tready  = tready_s;
    assign o_fifo_tdata   = tdata_q;
    assign o_fifo_tkeep   = tkeep_q;
    assign o_fifo_tuser   = tuser_q;
    assign o_fifo_tlast   = tlast_q;
    assign o_fifo_wr_en_0 = wr_en_q[0];
    assign o_fifo_wr_en_1 = wr_en_q[1];
    assign o_fifo_wr_en_2 = wr_en_q[2];
    assign o_fifo_wr_en_3 = wr_en_q[3];
    assign o_fifo_wr_en_4 = wr_en_q[4];
    assign o_fifo_wr_en_d = wr_en_q[5];
    assign o_drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_in_dispatcher.sv
// Table-driven bench for in_dispatcher; expectations adapt to DISPATCH_DROP_ON_FULL_EN.
module tb_in_dispatcher;

`ifdef DISPATCH_DROP_ON_FULL_EN
    localparam logic        DEF = 1'b1;
    localparam logic [31:0] DC  = 32'd1;
`else
    localparam logic        DEF = 1'b0;
    localparam logic [31:0] DC  = 32'd0;
`endif

    logic         clk;
    logic         rst;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic [127:0] tuser;
    logic         tlast;
    logic         tvalid;
    logic         tready;
    logic [255:0] o_tdata;
    logic [31:0]  o_tkeep;
    logic [127:0] o_tuser;
    logic         o_tlast;
    logic         wr_d, wr_0, wr_1, wr_2, wr_3, wr_4;
    logic [5:0]   full;
    logic [31:0]  drop_cnt;
    logic [5:0]   wr_all;

    int checks = 0;
    int errors = 0;

    assign wr_all = {wr_d, wr_4, wr_3, wr_2, wr_1, wr_0};

    in_dispatcher dut (
        .axis_aclk      (clk),
        .axis_reset     (rst),
        .s_axis_tdata   (tdata),
        .s_axis_tkeep   (tkeep),
        .s_axis_tuser   (tuser),
        .s_axis_tlast   (tlast),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .o_fifo_tdata   (o_tdata),
        .o_fifo_tkeep   (o_tkeep),
        .o_fifo_tuser   (o_tuser),
        .o_fifo_tlast   (o_tlast),
        .o_fifo_wr_en_d (wr_d),
        .o_fifo_wr_en_0 (wr_0),
        .o_fifo_wr_en_1 (wr_1),
        .o_fifo_wr_en_2 (wr_2),
        .o_fifo_wr_en_3 (wr_3),
        .o_fifo_wr_en_4 (wr_4),
        .i_fifo_full_d  (full[5]),
        .i_fifo_full_0  (full[0]),
        .i_fifo_full_1  (full[1]),
        .i_fifo_full_2  (full[2]),
        .i_fifo_full_3  (full[3]),
        .i_fifo_full_4  (full[4]),
        .o_drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each row: inputs for this cycle, expected tready now, and the registered
    // outputs produced by the previous row's handshake.
    typedef struct {
        logic        v;
        logic [7:0]  u;
        logic        l;
        logic [5:0]  f;
        logic [7:0]  db;
        logic        er;
        logic [5:0]  ew;
        logic        el;
        logic [7:0]  ed;
        logic [31:0] edc;
    } vec_t;

    vec_t tab [25];

    function automatic vec_t mk(logic v, logic [7:0] u, logic l, logic [5:0] f, logic [7:0] db,
                                logic er, logic [5:0] ew, logic el, logic [7:0] ed, logic [31:0] edc);
        vec_t r;
        r.v = v; r.u = u; r.l = l; r.f = f; r.db = db;
        r.er = er; r.ew = ew; r.el = el; r.ed = ed; r.edc = edc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] u, input logic l,
                         input logic [5:0] f, input logic [7:0] db);
        tvalid = v;
        tuser  = {96'd0, u, 24'd0};
        tlast  = l;
        full   = f;
        tdata  = {248'd0, db};
    endtask

    initial begin
        tab[0]  = mk(1'b1, 8'h04, 1'b0, 6'h00, 8'h10, 1'b1, 6'h00, 1'b0, 8'h00, 32'd0);
        tab[1]  = mk(1'b1, 8'h04, 1'b0, 6'h00, 8'h11, 1'b1, 6'h02, 1'b0, 8'h10, 32'd0);
        tab[2]  = mk(1'b1, 8'h04, 1'b1, 6'h00, 8'h12, 1'b1, 6'h02, 1'b0, 8'h11, 32'd0);
        tab[3]  = mk(1'b1, 8'h01, 1'b1, 6'h00, 8'h20, 1'b1, 6'h02, 1'b1, 8'h12, 32'd0);
        tab[4]  = mk(1'b1, 8'h40, 1'b1, 6'h00, 8'h21, 1'b1, 6'h01, 1'b1, 8'h20, 32'd0);
        tab[5]  = mk(1'b1, 8'h00, 1'b1, 6'h00, 8'h22, 1'b1, 6'h08, 1'b1, 8'h21, 32'd0);
        tab[6]  = mk(1'b1, 8'h02, 1'b1, 6'h00, 8'h23, 1'b1, 6'h20, 1'b1, 8'h22, 32'd0);
        tab[7]  = mk(1'b0, 8'h00, 1'b0, 6'h00, 8'hFF, 1'b1, 6'h10, 1'b1, 8'h23, 32'd0);
        tab[8]  = mk(1'b1, 8'h10, 1'b0, 6'h00, 8'h30, 1'b1, 6'h00, 1'b1, 8'h23, 32'd0);
        tab[9]  = mk(1'b1, 8'h10, 1'b0, 6'h00, 8'h31, 1'b1, 6'h04, 1'b0, 8'h30, 32'd0);
        tab[10] = mk(1'b1, 8'h10, 1'b0, 6'h04, 8'h32, 1'b0, 6'h04, 1'b0, 8'h31, 32'd0);
        for (int i = 11; i <= 14; i++)
            tab[i] = mk(1'b1, 8'h10, 1'b0, 6'h04, 8'h32, 1'b0, 6'h00, 1'b0, 8'h31, 32'd0);
        tab[15] = mk(1'b1, 8'h10, 1'b0, 6'h01, 8'h32, 1'b1, 6'h00, 1'b0, 8'h31, 32'd0);
        tab[16] = mk(1'b1, 8'h10, 1'b1, 6'h00, 8'h33, 1'b1, 6'h04, 1'b0, 8'h32, 32'd0);
        tab[17] = mk(1'b0, 8'h00, 1'b0, 6'h00, 8'hFF, 1'b1, 6'h04, 1'b1, 8'h33, 32'd0);
        tab[18] = mk(1'b1, 8'h01, 1'b0, 6'h01, 8'h40, DEF,  6'h00, 1'b1, 8'h33, 32'd0);
        tab[19] = mk(1'b1, 8'h01, 1'b1, 6'h01, 8'h41, DEF,  6'h00, 1'b1, 8'h33, DC);
        tab[20] = mk(1'b0, 8'h00, 1'b0, 6'h00, 8'hFF, 1'b1, 6'h00, 1'b1, 8'h33, DC);
        tab[21] = mk(1'b1, 8'h05, 1'b0, 6'h00, 8'h50, 1'b1, 6'h00, 1'b1, 8'h33, DC);
        tab[22] = mk(1'b1, 8'h01, 1'b1, 6'h00, 8'h51, 1'b1, 6'h20, 1'b0, 8'h50, DC);
        tab[23] = mk(1'b0, 8'h00, 1'b0, 6'h00, 8'hFF, 1'b1, 6'h20, 1'b1, 8'h51, DC);
        tab[24] = mk(1'b0, 8'h05, 1'b0, 6'h20, 8'hFF, DEF,  6'h00, 1'b1, 8'h51, DC);

        tkeep = 32'hFFFF_FFFF;
        drive(1'b0, 8'h00, 1'b0, 6'h00, 8'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_tready", 64'(tready), 64'd1);
        chk("reset_wr_en", 64'(wr_all), 64'd0);
        chk("reset_tdata", 64'(o_tdata[63:0]), 64'd0);
        chk("reset_tlast", 64'(o_tlast), 64'd0);
        chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(tab[i].v, tab[i].u, tab[i].l, tab[i].f, tab[i].db);
            #1;
            chk($sformatf("v%0d_tready", i), 64'(tready), 64'(tab[i].er));
            chk($sformatf("v%0d_wr_en", i), 64'(wr_all), 64'(tab[i].ew));
            chk($sformatf("v%0d_tlast", i), 64'(o_tlast), 64'(tab[i].el));
            chk($sformatf("v%0d_tdata", i), 64'(o_tdata[7:0]), 64'(tab[i].ed));
            chk($sformatf("v%0d_drop_cnt", i), 64'(drop_cnt), 64'(tab[i].edc));
        end

        // Reset during beat 2 of a packet, then a fresh packet to FIFO 4.
        @(negedge clk);
        drive(1'b1, 8'h04, 1'b0, 6'h00, 8'h60);
        @(negedge clk);
        drive(1'b1, 8'h04, 1'b0, 6'h00, 8'h61);
        rst = 1'b1;
        #1;
        chk("rst_seq_beat1_wr", 64'(wr_all), 64'h02);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 6'h00, 8'h00);
        #1;
        chk("rst_seq_wr_clear", 64'(wr_all), 64'd0);
        chk("rst_seq_tdata", 64'(o_tdata[63:0]), 64'd0);
        chk("rst_seq_tuser", 64'(o_tuser[63:0]), 64'd0);
        chk("rst_seq_tlast", 64'(o_tlast), 64'd0);
        chk("rst_seq_drop_cnt", 64'(drop_cnt), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 8'h08, (k == 2), 6'h00, 8'(8'h70 + k));
            #1;
            chk($sformatf("pkt8_b%0d_tready", k), 64'(tready), 64'd1);
            if (k > 0) begin
                chk($sformatf("pkt8_b%0d_wr", k - 1), 64'(wr_all), 64'h10);
                chk($sformatf("pkt8_b%0d_tdata", k - 1), 64'(o_tdata[7:0]), 64'(8'h70 + k - 1));
            end
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 6'h00, 8'h00);
        #1;
        chk("pkt8_b2_wr", 64'(wr_all), 64'h10);
        chk("pkt8_b2_tlast", 64'(o_tlast), 64'd1);
        chk("pkt8_b2_tuser", 64'(o_tuser[31:24]), 64'h08);
        chk("pkt8_b2_tkeep", 64'(o_tkeep), 64'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("pkt8_idle_wr", 64'(wr_all), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
